// File: rtl/spi_master_ctrl.sv
// SPI master: serializes one command frame (select cycle, cmd bit, frame MSB first)
// and, for read-data frames, captures the slave's MISO reply after a turnaround gap.
module spi_master_ctrl #(
  parameter int unsigned FRAME_W    = 10,
  parameter int unsigned RD_W       = 8,
  parameter int unsigned TURNAROUND = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic               abort,
  input  logic               MISO,
  output logic               SS_n,
  output logic               MOSI,
  output logic               busy,
  output logic               done,
  output logic [RD_W-1:0]    rd_data,
  output logic               rd_valid
);

  localparam int unsigned BCNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned RCNT_W = (RD_W > 1) ? $clog2(RD_W) : 1;
  localparam int unsigned TCNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_SEND,
    S_TURN,
    S_RECV,
    S_FIN
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  frame_q;
  logic [BCNT_W-1:0]   bcnt;
  logic [TCNT_W-1:0]   tcnt;
  logic [RCNT_W-1:0]   rcnt;
  logic [RD_W-1:0]     shreg;
  logic [RD_W-1:0]     shreg_nxt;
  logic                is_rd;

  assign is_rd     = (frame_q[FRAME_W-1:FRAME_W-2] == 2'b11);
  assign shreg_nxt = RD_W'({shreg, MISO});

  // Outputs are registered alongside the state, so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      frame_q  <= '0;
      bcnt     <= '0;
      tcnt     <= '0;
      rcnt     <= '0;
      shreg    <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      if ((state != S_IDLE) && abort) begin
        // Abort drops the slave select at once and discards any partial capture.
        state <= S_IDLE;
        SS_n  <= 1'b1;
        MOSI  <= 1'b0;
        busy  <= 1'b0;
        bcnt  <= '0;
        tcnt  <= '0;
        rcnt  <= '0;
        shreg <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              frame_q <= frame;
              state   <= S_SEL;
              SS_n    <= 1'b0;
              busy    <= 1'b1;
              MOSI    <= frame[FRAME_W-1];
            end
          end
          S_SEL: begin
            state <= S_SEND;
            MOSI  <= frame_q[FRAME_W-1];
            bcnt  <= BCNT_W'(FRAME_W - 1);
          end
          S_SEND: begin
            if (bcnt != '0) begin
              bcnt <= bcnt - BCNT_W'(1);
              MOSI <= frame_q[bcnt - BCNT_W'(1)];
            end else begin
              MOSI <= 1'b0;
              if (!is_rd) begin
                state <= S_FIN;
                SS_n  <= 1'b1;
                done  <= 1'b1;
              end else if (TURNAROUND != 0) begin
                state <= S_TURN;
                tcnt  <= TCNT_W'(TURNAROUND - 1);
              end else begin
                state <= S_RECV;
                rcnt  <= RCNT_W'(RD_W - 1);
              end
            end
          end
          S_TURN: begin
            if (tcnt != '0) begin
              tcnt <= tcnt - TCNT_W'(1);
            end else begin
              state <= S_RECV;
              rcnt  <= RCNT_W'(RD_W - 1);
            end
          end
          S_RECV: begin
            // MISO arrives MSB first; the final sample goes straight into rd_data.
            if (rcnt != '0) begin
              rcnt  <= rcnt - RCNT_W'(1);
              shreg <= shreg_nxt;
            end else begin
              state    <= S_FIN;
              SS_n     <= 1'b1;
              done     <= 1'b1;
              rd_valid <= 1'b1;
              rd_data  <= shreg_nxt;
              shreg    <= '0;
            end
          end
          S_FIN: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            SS_n  <= 1'b1;
            MOSI  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomized scoreboard bench for spi_master_ctrl with a cycle-level slave/host driver.
module tb_spi_master_ctrl;

  localparam int unsigned FRAME_W    = 10;
  localparam int unsigned RD_W       = 8;
  localparam int unsigned TURNAROUND = 2;
  localparam int          RX_FIRST   = 2 + FRAME_W + TURNAROUND;
  localparam int          RX_LAST    = RX_FIRST + RD_W - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [FRAME_W-1:0] frame;
  logic               abort;
  logic               MISO;
  logic               SS_n;
  logic               MOSI;
  logic               busy;
  logic               done;
  logic [RD_W-1:0]    rd_data;
  logic               rd_valid;

  spi_master_ctrl #(
    .FRAME_W   (FRAME_W),
    .RD_W      (RD_W),
    .TURNAROUND(TURNAROUND)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .frame   (frame),
    .abort   (abort),
    .MISO    (MISO),
    .SS_n    (SS_n),
    .MOSI    (MOSI),
    .busy    (busy),
    .done    (done),
    .rd_data (rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FRAME_W-1:0] f;
    logic               is_rd;
    logic [RD_W-1:0]    rd;
  } exp_t;

  exp_t            sb[$];
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [RD_W-1:0] last_rd  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: collects MOSI while SS_n is low and scores each completed transaction.
  int   low_len   = 0;
  logic mosi_bits[$];
  logic prev_done = 1'b0;
  exp_t e;
  int   exp_len;
  int   nbad;
  logic exp_bit;

  always @(negedge clk) begin
    if (prev_done) check("idle_after_done", {30'd0, SS_n, busy}, 32'b10);
    prev_done = done;
    if (!SS_n) begin
      low_len++;
      mosi_bits.push_back(MOSI);
    end
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        exp_len = 1 + FRAME_W + (e.is_rd ? (TURNAROUND + RD_W) : 0);
        check("ss_low_len", low_len, exp_len);
        nbad = 0;
        for (int i = 0; i < mosi_bits.size(); i++) begin
          if (i == 0) exp_bit = e.f[FRAME_W-1];
          else if (i <= FRAME_W) exp_bit = e.f[FRAME_W-i];
          else exp_bit = 1'b0;
          if (mosi_bits[i] !== exp_bit) nbad++;
        end
        check("mosi_stream", nbad, 0);
        check("busy_at_done", busy, 1);
        check("rd_valid", rd_valid, e.is_rd);
        check("rd_data", rd_data, e.rd);
      end
      low_len = 0;
      mosi_bits.delete();
    end else begin
      if (rd_valid) check("rd_valid_without_done", 1, 0);
      if (!busy) begin
        low_len = 0;
        mosi_bits.delete();
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) @(negedge clk);
    if (busy) check("idle_timeout", busy, 0);
  endtask

  // Driver: cycle 0 is the cycle whose closing edge accepts start; inputs change at negedges.
  task automatic run_txn(input logic [FRAME_W-1:0] f, input logic [RD_W-1:0] reply,
                         input int abort_at, input int rst_at, input bit junk,
                         input bit abort_with_start);
    bit rd;
    int n_end;
    rd    = (f[FRAME_W-1 -: 2] == 2'b11);
    n_end = rd ? RX_LAST + 1 : 2 + FRAME_W;
    wait_idle();
    start = 1'b1;
    frame = f;
    abort = abort_with_start;
    MISO  = 1'($urandom);
    if (abort_at == 0 && rst_at == 0) begin
      sb.push_back('{f: f, is_rd: rd, rd: rd ? reply : last_rd});
      if (rd) last_rd = reply;
    end
    @(negedge clk);
    for (int k = 1; k <= n_end; k++) begin
      if (k == 1) begin
        check("sel_cycle", {30'd0, SS_n, busy}, 32'b01);
        check("cmd_bit", MOSI, f[FRAME_W-1]);
      end
      if (abort_at != 0 && k == abort_at + 1) begin
        check("abort_outputs", {28'd0, SS_n, busy, done, rd_valid}, 32'b1000);
        check("abort_rd_hold", rd_data, last_rd);
        start = 1'b0;
        abort = 1'b0;
        return;
      end
      if (rst_at != 0 && k == rst_at + 1) begin
        check("rst_outputs", {27'd0, SS_n, MOSI, busy, done, rd_valid}, 32'b10000);
        check("rst_rd_data", rd_data, 0);
        last_rd = '0;
        rst     = 1'b0;
        start   = 1'b0;
        return;
      end
      start = junk ? 1'($urandom_range(0, 1)) : 1'b0;
      frame = junk ? FRAME_W'(10'h1FF) : FRAME_W'($urandom);
      abort = (k == abort_at);
      rst   = (k == rst_at);
      MISO  = (rd && k >= RX_FIRST && k <= RX_LAST) ? reply[RX_LAST - k] : 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    logic [FRAME_W-1:0] rf;
    logic [RD_W-1:0]    rr;
    int                 ab;
    int                 rend;
    rst   = 1'b1;
    start = 1'b0;
    frame = '0;
    abort = 1'b0;
    MISO  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ss_n", SS_n, 1);
    check("reset_mosi", MOSI, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_rd_data", rd_data, 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(10'h0A5, 8'h00, 0, 0, 1'b1, 1'b0);
    run_txn(10'h300, 8'h3C, 0, 0, 1'b0, 1'b0);
    run_txn(10'h0A5, 8'h00, 0, 0, 1'b0, 1'b0);
    run_txn(10'h2A5, 8'h00, 0, 0, 1'b0, 1'b0);
    run_txn(10'h300, 8'hC3, 17, 0, 1'b0, 1'b0);

    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_noop", {30'd0, SS_n, busy}, 32'b10);

    run_txn(10'h2A5, 8'h00, 0, 6, 1'b0, 1'b0);
    run_txn(10'h3FF, 8'h81, 0, 0, 1'b1, 1'b1);
    run_txn(10'h1FF, 8'h00, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      rf   = FRAME_W'($urandom);
      rr   = RD_W'($urandom);
      rend = (rf[FRAME_W-1 -: 2] == 2'b11) ? RX_LAST + 1 : 2 + FRAME_W;
      ab   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, rend - 1) : 0;
      run_txn(rf, rr, ab, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Host-side SPI master that sits directly upstream of the SPI slave / RAM wrapper. It turns one parallel 10-bit command frame from the host into the serial SS_n/MOSI sequence the slave's CHK_CMD/WRITE/READ_ADD/READ_DATA flow expects.
- For read-data frames it also captures the 8-bit MISO reply.
- SCLK is the shared system clock `clk`; the master drives MOSI and samples MISO on rising edges.

Parameters:
- FRAME_W, 10, bits per command frame; frame[FRAME_W-1:FRAME_W-2] is the opcode: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- RD_W, 8, bits returned on MISO for a read-data frame.
- TURNAROUND, 2, idle cycles (SS_n low, MOSI=0) between the last frame bit and the first MISO sample; legal range 0..15.

Ports:
- clk  in  1  system clock, also the SPI clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; sampled only when busy=0.
- frame  in  FRAME_W  command frame, latched on an accepted start.
- abort  in  1  synchronous abort of the current transaction.
- MISO  in  1  serial data from the slave.
- SS_n  out  1  active-low slave select.
- MOSI  out  1  serial data to the slave.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse when a transaction completes normally.
- rd_data  out  RD_W  captured read-data reply.
- rd_valid  out  1  one-cycle pulse qualifying rd_data.

Behaviour:
- Reset values (also forced on any cycle with rst=1, including mid-transaction): SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE, all counters 0.
- Outputs are registered. Cycle 0 is the edge where start is accepted.
- States:
  - IDLE: SS_n=1, busy=0. On start=1, latch frame → SEL. start is ignored whenever busy=1.
  - SEL (1 cycle, cycle 1): SS_n=0, busy=1, MOSI=cmd bit=frame[FRAME_W-1] (0 = write path, 1 = read path) → SEND.
  - SEND (FRAME_W cycles, cycles 2..FRAME_W+1): MOSI=frame bits MSB first; bit counter counts FRAME_W-1 down to 0.
    - Exit when the counter reaches 0: to TURN if opcode=11, else to END.
  - TURN (TURNAROUND cycles): MOSI=0, SS_n=0. If TURNAROUND=0, go straight from SEND to RECV.
  - RECV (RD_W cycles): MOSI=0; MISO is shifted MSB first into the capture register on each edge → END after RD_W samples.
  - END (1 cycle): SS_n=1, MOSI=0, busy=1, done=1. rd_valid=1 and rd_data updated only for opcode=11 → IDLE.
- Timing with defaults:
  - Non-read-data frame: SS_n low cycles 1..11, done in cycle 12, next start accepted in cycle 13.
  - Read-data frame: turnaround cycles 12–13, MISO sampled at the ends of cycles 14..21, done and rd_valid in cycle 22.
- rd_data holds its value until the next read-data completion or reset.
- Abort:
  - abort=1 in any state except IDLE: next cycle SS_n=1, MOSI=0, busy=0, state=IDLE.
  - done and rd_valid are not asserted; rd_data is unchanged and a partial capture is discarded.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Minimum SS_n high time between transactions is 2 cycles (END + IDLE), so back-to-back frames always return the slave to IDLE.
- A frame latched at start is unaffected by later changes on the frame input.

Test Plan:
- Reset, then start with frame=10'h0A5 → MOSI in cycles 1..11 = 0, 0,0,1,0,1,0,0,1,0,1; SS_n low cycles 1..11; done=1 only in cycle 12; rd_valid stays 0.
- start with frame=10'h300, slave model drives 0x3C on MISO in cycles 14..21 → MOSI cmd bit 1; rd_valid=1 and rd_data=8'h3C in cycle 22; busy=0 in cycle 23.
- Assert start with frame=10'h1FF in cycles 1..12 of a running 10'h0A5 transaction → ignored; only one done pulse; MOSI shows the 10'h0A5 bits only.
- Back-to-back: start held high with 10'h0A5 then 10'h2A5 → second SS_n fall in cycle 14; second done in cycle 25.
- abort in cycle 17 of a 10'h300 read → SS_n=1 and busy=0 in cycle 18; no done or rd_valid; rd_data keeps the previous value 8'h3C.
- rst=1 in cycle 6 of any frame → all outputs at reset values on the next edge; a new start after reset completes normally.
